// File: rtl/master_port_serial.sv
// Master-side serial bus port.
// Takes one parallel request from a local master and shifts the address, then
// the write data for writes, MSB-first onto wr_bus. For reads it collects
// DATA_WIDTH bits from rd_bus and returns them as one parallel response.
// Ports:
//   clk, rstn                         clock, async active-low reset
//   req_valid/req_ready/req_wr/
//   req_addr/req_wdata                 parallel request from the local master
//   rsp_valid/rsp_rdata/rsp_err        one-cycle parallel response
//   mode, wr_bus, master_valid,
//   master_ready                       serial side toward the slave
//   rd_bus, slave_ready, slave_valid,
//   split                              serial side from the slave
module master_port_serial #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mode,
    output logic                  wr_bus,
    output logic                  master_valid,
    output logic                  master_ready,
    input  logic                  rd_bus,
    input  logic                  slave_ready,
    input  logic                  slave_valid,
    input  logic                  split
);

    localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT_RD, RECV, RESP} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_sr, addr_sr_n;
    logic [DATA_WIDTH-1:0] data_sr, data_sr_n;
    logic [DATA_WIDTH-1:0] rdata_sr, rdata_sr_n;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [TO_W-1:0]       to_cnt, to_cnt_n;
    logic                  wake, wake_n;
    logic                  mode_n;
    logic                  err_n;
    logic                  rx_bit;

    // A released (split) bus carries no read data even if slave_valid is high.
    assign rx_bit = slave_valid & ~split;

    // Next-state and datapath update.
    always_comb begin
        state_n    = state;
        addr_sr_n  = addr_sr;
        data_sr_n  = data_sr;
        rdata_sr_n = rdata_sr;
        bit_cnt_n  = bit_cnt;
        to_cnt_n   = to_cnt;
        wake_n     = 1'b0;
        mode_n     = mode;
        err_n      = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_sr_n  = req_addr;
                    data_sr_n  = req_wdata;
                    rdata_sr_n = '0;
                    mode_n     = req_wr;
                    bit_cnt_n  = '0;
                    to_cnt_n   = '0;
                    wake_n     = 1'b1;
                    state_n    = ADDR;
                end
            end
            ADDR: begin
                // The first ADDR cycle only wakes the slave; no shift, no abort.
                if (!wake) begin
                    if (!slave_ready) begin
                        state_n = RESP;
                        err_n   = 1'b1;
                    end else begin
                        addr_sr_n = {addr_sr[ADDR_WIDTH-2:0], 1'b0};
                        if (bit_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                            bit_cnt_n = '0;
                            state_n   = mode ? DATA : WAIT_RD;
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            DATA: begin
                if (!slave_ready) begin
                    state_n = RESP;
                    err_n   = 1'b1;
                end else begin
                    data_sr_n = {data_sr[DATA_WIDTH-2:0], 1'b0};
                    if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = RESP;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
            WAIT_RD: begin
                if (rx_bit) begin
                    rdata_sr_n = {rdata_sr[DATA_WIDTH-2:0], rd_bus};
                    bit_cnt_n  = CNT_W'(1);
                    state_n    = RECV;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_n = RESP;
                    err_n   = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + TO_W'(1);
                end
            end
            RECV: begin
                if (rx_bit) begin
                    rdata_sr_n = {rdata_sr[DATA_WIDTH-2:0], rd_bus};
                    if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = RESP;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end else begin
                    rdata_sr_n = '0;
                    state_n    = RESP;
                    err_n      = 1'b1;
                end
            end
            RESP: begin
                mode_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs (outputs track the next state).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            addr_sr      <= '0;
            data_sr      <= '0;
            rdata_sr     <= '0;
            bit_cnt      <= '0;
            to_cnt       <= '0;
            wake         <= 1'b0;
            mode         <= 1'b0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            wr_bus       <= 1'b0;
            master_valid <= 1'b0;
            master_ready <= 1'b0;
        end else begin
            state        <= state_n;
            addr_sr      <= addr_sr_n;
            data_sr      <= data_sr_n;
            rdata_sr     <= rdata_sr_n;
            bit_cnt      <= bit_cnt_n;
            to_cnt       <= to_cnt_n;
            wake         <= wake_n;
            mode         <= mode_n;
            req_ready    <= (state_n == IDLE);
            rsp_valid    <= (state_n == RESP);
            rsp_rdata    <= (state_n == RESP) ? rdata_sr_n : '0;
            rsp_err      <= err_n;
            master_valid <= (state_n == ADDR) || (state_n == DATA);
            master_ready <= (state_n == WAIT_RD) || (state_n == RECV);
            wr_bus       <= (state_n == ADDR) ? addr_sr_n[ADDR_WIDTH-1] :
                            (state_n == DATA) ? data_sr_n[DATA_WIDTH-1] : 1'b0;
        end
    end

endmodule

// File: tb/tb_master_port_serial.sv
// Directed self-checking bench for master_port_serial (16-bit address, 8-bit data, TIMEOUT 64).
module tb_master_port_serial;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        mode;
    logic        wr_bus;
    logic        master_valid;
    logic        master_ready;
    logic        rd_bus;
    logic        slave_ready;
    logic        slave_valid;
    logic        split;

    int tests  = 0;
    int failed = 0;

    master_port_serial #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(64)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid), .master_ready(master_ready),
        .rd_bus(rd_bus), .slave_ready(slave_ready), .slave_valid(slave_valid), .split(split)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble the request inputs.
    task automatic accept(input logic wr, input logic [15:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        check("accept_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_wr    = ~wr;
        req_addr  = ~a;
        req_wdata = ~d;
    endtask

    // Leave the wake cycle, then clock out the 16 address bits.
    task automatic shift_addr(output logic [15:0] cap, output logic mv_ok);
        slave_ready = 1'b0;
        tick();
        slave_ready = 1'b1;
        cap   = '0;
        mv_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cap   = {cap[14:0], wr_bus};
            mv_ok = mv_ok & master_valid;
            tick();
        end
    endtask

    // Slave returns one byte MSB-first on consecutive cycles.
    task automatic send_rd(input logic [7:0] v, output logic mr_ok);
        mr_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            slave_valid = 1'b1;
            rd_bus      = v[7-i];
            mr_ok       = mr_ok & master_ready;
            tick();
        end
        slave_valid = 1'b0;
        rd_bus      = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input string tag);
        logic [15:0] cap_a;
        logic [7:0]  cap_d;
        logic        ok;
        logic        mode_ok;
        accept(1'b1, a, d);
        check({tag, "_wake_mv"}, 32'(master_valid), 32'd1);
        check({tag, "_wake_mode"}, 32'(mode), 32'd1);
        shift_addr(cap_a, ok);
        check({tag, "_addr_bits"}, 32'(cap_a), 32'(a));
        check({tag, "_addr_mv"}, 32'(ok), 32'd1);
        cap_d   = '0;
        mode_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cap_d   = {cap_d[6:0], wr_bus};
            mode_ok = mode_ok & mode & master_valid;
            tick();
        end
        slave_ready = 1'b0;
        check({tag, "_data_bits"}, 32'(cap_d), 32'(d));
        check({tag, "_data_mode"}, 32'(mode_ok), 32'd1);
        check({tag, "_rsp"}, {29'd0, rsp_valid, rsp_err, master_valid}, {29'd0, 1'b1, 1'b0, 1'b0});
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        // A request offered during RESP must not be taken.
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check({tag, "_idle"}, {28'd0, rsp_valid, master_valid, req_ready, mode},
              {28'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        logic [15:0] cap_a;
        logic        ok;
        logic        seen;
        int          n;

        rstn = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        rd_bus = 1'b0; slave_ready = 1'b0; slave_valid = 1'b0; split = 1'b0;
        tick();
        tick();
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_outs", {18'd0, rsp_valid, rsp_err, mode, wr_bus, master_valid, master_ready, rsp_rdata}, 32'd0);
        rstn = 1'b1;
        tick();

        // Write A=0xA5C3 D=0x5A.
        do_write(16'hA5C3, 8'h5A, "wr1");

        // Read A=0x0010 with a 4-cycle slave latency, data 0xC4.
        accept(1'b0, 16'h0010, 8'hFF);
        check("rd1_mode", 32'(mode), 32'd0);
        shift_addr(cap_a, ok);
        slave_ready = 1'b0;
        check("rd1_addr_bits", 32'(cap_a), 32'h0010);
        check("rd1_wait", {30'd0, master_ready, master_valid}, {30'd0, 1'b1, 1'b0});
        repeat (3) tick();
        send_rd(8'hC4, ok);
        check("rd1_mr_recv", 32'(ok), 32'd1);
        check("rd1_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, {22'd0, 1'b1, 1'b0, 8'hC4});
        tick();
        check("rd1_idle", 32'(req_ready), 32'd1);

        // Read with split held for 6 cycles, then data 0x3B.
        accept(1'b0, 16'h8001, 8'h00);
        shift_addr(cap_a, ok);
        slave_ready = 1'b0;
        split = 1'b1;
        repeat (6) tick();
        check("split_wait", {30'd0, rsp_valid, master_ready}, {30'd0, 1'b0, 1'b1});
        split = 1'b0;
        send_rd(8'h3B, ok);
        check("split_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, {22'd0, 1'b1, 1'b0, 8'h3B});
        tick();

        // Slave never answers: error exactly 64 cycles after entering WAIT_RD.
        accept(1'b0, 16'h00FF, 8'h00);
        shift_addr(cap_a, ok);
        slave_ready = 1'b0;
        split = 1'b1;
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd64);
        check("timeout_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, {22'd0, 1'b1, 1'b1, 8'h00});
        split = 1'b0;
        tick();

        // slave_valid drops after 3 read bits: error with zero data.
        accept(1'b0, 16'h4242, 8'h00);
        shift_addr(cap_a, ok);
        slave_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            slave_valid = 1'b1;
            rd_bus      = 1'b1;
            tick();
        end
        slave_valid = 1'b0;
        rd_bus      = 1'b0;
        tick();
        check("recv_abort", {22'd0, rsp_valid, rsp_err, rsp_rdata}, {22'd0, 1'b1, 1'b1, 8'h00});
        tick();

        // slave_ready drops at address bit 5.
        accept(1'b1, 16'h1357, 8'h24);
        tick();
        slave_ready = 1'b1;
        repeat (5) tick();
        slave_ready = 1'b0;
        check("addr_abort_before", 32'(master_valid), 32'd1);
        tick();
        check("addr_abort_rsp", {28'd0, rsp_valid, rsp_err, master_valid, wr_bus},
              {28'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        tick();
        check("addr_abort_idle", {30'd0, req_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});

        // Reset pulsed during data bit 3: immediate reset, no response.
        accept(1'b1, 16'hBEEF, 8'h96);
        shift_addr(cap_a, ok);
        repeat (3) tick();
        check("pre_reset_mv", 32'(master_valid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset", {26'd0, req_ready, rsp_valid, mode, wr_bus, master_valid, master_ready},
              {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        slave_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | rsp_valid;
        end
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            seen = seen | rsp_valid;
        end
        check("reset_no_rsp", 32'(seen), 32'd0);

        do_write(16'h1234, 8'hC3, "wr2");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
